// File: rtl/ahb2mem_if.sv
// rtl/ahb2mem_if.sv - mem request/response types and the AHB-Lite + mem bundle seen by ahb2mem
package ahb2mem_pkg;
   localparam int MEM_AW = 32;
   localparam int MEM_DW = 32;

   typedef enum logic {
      MEM_READ  = 1'b0,
      MEM_WRITE = 1'b1
   } mem_type_e;

   typedef struct packed {
      mem_type_e         req_type;
      logic [MEM_AW-1:0] req_addr;
      logic [MEM_DW-1:0] req_data;
      logic [3:0]        req_mask;
      logic [3:0]        req_burst;
   } mem_req_t;

   typedef struct packed {
      logic [1:0]        resp_type;
      logic [MEM_DW-1:0] resp_data;
      logic              resp_last;
   } mem_resp_t;
endpackage

interface ahb2mem_if #(
   parameter int N_AW = 32,
   parameter int N_DW = 32
);
   import ahb2mem_pkg::*;

   logic            hsel;
   logic [1:0]      htrans;
   logic [N_AW-1:0] haddr;
   logic [2:0]      hsize;
   logic [2:0]      hburst;
   logic            hwrite;
   logic [N_DW-1:0] hwdata;
   logic            hready;
   logic            hreadyout;
   logic            hresp;
   logic [N_DW-1:0] hrdata;
   logic            mem_req_valid;
   logic            mem_req_ready;
   mem_req_t        mem_req;
   logic            mem_resp_valid;
   logic            mem_resp_ready;
   mem_resp_t       mem_resp;

   modport slave (
      input  hsel, htrans, haddr, hsize, hburst, hwrite, hwdata, hready,
      input  mem_req_ready, mem_resp_valid, mem_resp,
      output hreadyout, hresp, hrdata, mem_req_valid, mem_req, mem_resp_ready
   );

   modport master (
      output hsel, htrans, haddr, hsize, hburst, hwrite, hwdata, hready,
      output mem_req_ready, mem_resp_valid, mem_resp,
      input  hreadyout, hresp, hrdata, mem_req_valid, mem_req, mem_resp_ready
   );
endinterface

// File: rtl/ahb2mem.sv
// rtl/ahb2mem.sv - AHB-Lite slave bridging single transfers onto mem_req/mem_resp.
// Define AHB2MEM_WR_POST_EN for posted writes (write completes on request handshake).
module ahb2mem
   import ahb2mem_pkg::*;
#(
   parameter int N_AW = 32,
   parameter int N_DW = 32
) (
   input  logic       clk,
   input  logic       rstn,
   ahb2mem_if.slave   bus
);

   typedef enum logic [2:0] {
      S_IDLE,
      S_REQ,
      S_RESP,
      S_DONE,
      S_ERR1,
      S_ERR2
   } state_e;

   state_e          state_q, state_d;
   logic [N_AW-1:0] haddr_q;
   logic [1:0]      hsize_q;
   logic            hwrite_q;
   logic            hreadyout_q;
   logic            hresp_q;
   logic [N_DW-1:0] hrdata_q;
   logic            mem_req_valid_q;
   logic            mem_resp_ready_q;

   logic            acc, legal, req_hs, resp_hs, post_wr, pend_wr_d;
   logic [3:0]      mask;
   mem_req_t        req;

   assign acc     = bus.hsel & bus.htrans[1] & bus.hready;
   assign legal   = (bus.hsize == 3'd0)
                  | ((bus.hsize == 3'd1) & ~bus.haddr[0])
                  | ((bus.hsize == 3'd2) & (bus.haddr[1:0] == 2'b00));
   assign req_hs  = mem_req_valid_q & bus.mem_req_ready;
   assign resp_hs = mem_resp_ready_q & bus.mem_resp_valid;

`ifdef AHB2MEM_WR_POST_EN
   logic pend_wr_q;

   assign post_wr = hwrite_q;

   // One write response may still be in flight; it is swallowed here.
   always_comb begin
      pend_wr_d = pend_wr_q;
      if ((state_q == S_REQ) && req_hs && hwrite_q) begin
         pend_wr_d = 1'b1;
      end else if (pend_wr_q && resp_hs) begin
         pend_wr_d = 1'b0;
      end
   end
`else
   assign post_wr   = 1'b0;
   assign pend_wr_d = 1'b0;
`endif

   always_comb begin
      state_d = state_q;
      case (state_q)
         S_IDLE, S_DONE, S_ERR2: state_d = acc ? (legal ? S_REQ : S_ERR1) : S_IDLE;
         S_REQ:  if (req_hs) state_d = post_wr ? S_DONE : S_RESP;
         S_RESP: if (resp_hs) state_d = S_DONE;
         S_ERR1: state_d = S_ERR2;
         default: state_d = S_IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (!rstn) begin
         state_q          <= S_IDLE;
         haddr_q          <= '0;
         hsize_q          <= '0;
         hwrite_q         <= 1'b0;
         hreadyout_q      <= 1'b1;
         hresp_q          <= 1'b0;
         hrdata_q         <= '0;
         mem_req_valid_q  <= 1'b0;
         mem_resp_ready_q <= 1'b0;
`ifdef AHB2MEM_WR_POST_EN
         pend_wr_q        <= 1'b0;
`endif
      end else begin
         state_q <= state_d;
         if ((state_q inside {S_IDLE, S_DONE, S_ERR2}) && acc) begin
            haddr_q  <= bus.haddr;
            hsize_q  <= bus.hsize[1:0];
            hwrite_q <= bus.hwrite;
         end
         if ((state_q == S_RESP) && resp_hs && !hwrite_q) begin
            hrdata_q <= N_DW'(bus.mem_resp.resp_data);
         end
         // Outputs are decoded from the next state so they leave the flops clean.
         hreadyout_q      <= state_d inside {S_IDLE, S_DONE, S_ERR2};
         hresp_q          <= state_d inside {S_ERR1, S_ERR2};
         mem_req_valid_q  <= (state_d == S_REQ) && !pend_wr_d;
         mem_resp_ready_q <= (state_d == S_RESP) || pend_wr_d;
`ifdef AHB2MEM_WR_POST_EN
         pend_wr_q        <= pend_wr_d;
`endif
      end
   end

   always_comb begin
      mask = 4'hF;
      case (hsize_q)
         2'd0:    mask = 4'b0001 << haddr_q[1:0];
         2'd1:    mask = 4'b0011 << {haddr_q[1], 1'b0};
         default: mask = 4'hF;
      endcase
   end

   // hwdata is taken live: the master holds it through the wait states.
   always_comb begin
      req           = '0;
      req.req_type  = hwrite_q ? MEM_WRITE : MEM_READ;
      req.req_addr  = MEM_AW'(haddr_q);
      req.req_data  = MEM_DW'(bus.hwdata);
      req.req_mask  = mask;
      req.req_burst = 4'd1;
   end

   assign bus.hreadyout      = hreadyout_q;
   assign bus.hresp          = hresp_q;
   assign bus.hrdata         = hrdata_q;
   assign bus.mem_req_valid  = mem_req_valid_q;
   assign bus.mem_req        = req;
   assign bus.mem_resp_ready = mem_resp_ready_q;

   logic unused_bits;
   assign unused_bits = ^{bus.hburst, bus.htrans[0], bus.mem_resp.resp_type, bus.mem_resp.resp_last};

endmodule

// File: tb/tb_ahb2mem.sv
// tb/tb_ahb2mem.sv - randomized AHB master and mem agent against a transfer-level model of ahb2mem
module tb_ahb2mem;
   import ahb2mem_pkg::*;

`ifdef AHB2MEM_WR_POST_EN
   localparam bit POSTED = 1'b1;
`else
   localparam bit POSTED = 1'b0;
`endif

   logic clk = 1'b0;
   logic rstn = 1'b0;
   always #5 clk = ~clk;

   ahb2mem_if #(.N_AW(32), .N_DW(32)) bus ();
   assign bus.hready = bus.hreadyout;

   ahb2mem #(.N_AW(32), .N_DW(32)) dut (
      .clk  (clk),
      .rstn (rstn),
      .bus  (bus)
   );

   typedef struct {
      logic [31:0] addr;
      int          size;
      bit          wr;
      logic [31:0] wdata;
      logic [31:0] rdata;
      int          stall;
      int          dly;
      int          gap;
   } tr_t;

   tr_t stim[$];
   tr_t expq[$];
   int  n_vec = 0;
   int  n_err = 0;

   task automatic check(input string tag, input logic [127:0] got, input logic [127:0] exp);
      n_vec++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   function automatic bit legal_f(input tr_t t);
      int nb;
      if (t.size > 2) return 1'b0;
      nb = 1 << t.size;
      return (t.addr % nb) == 0;
   endfunction

   function automatic logic [3:0] mask_f(input tr_t t);
      int nb, lane;
      logic [7:0] m;
      nb   = 1 << t.size;
      lane = int'(t.addr % 4);
      m    = 8'((1 << nb) - 1) << lane;
      return m[3:0];
   endfunction

   task automatic add(input logic [31:0] a, input int sz, input bit w, input logic [31:0] wd,
                      input logic [31:0] rd, input int st, input int dl, input int gp);
      tr_t t;
      t.addr = a; t.size = sz; t.wr = w; t.wdata = wd; t.rdata = rd;
      t.stall = st; t.dly = dl; t.gap = gp;
      stim.push_back(t);
   endtask

   task automatic drive_idle();
      case ($urandom_range(0, 2))
         0:       begin bus.hsel = 1'b0; bus.htrans = 2'b10; end
         1:       begin bus.hsel = 1'b1; bus.htrans = 2'b00; end
         default: begin bus.hsel = 1'b1; bus.htrans = 2'b01; end
      endcase
      bus.haddr  = $urandom;
      bus.hsize  = 3'($urandom_range(0, 3));
      bus.hwrite = 1'($urandom_range(0, 1));
   endtask

   tr_t         ap, dp, t;
   bit          ap_valid = 0, dp_act = 0, dp_legal = 0, dp_exact = 0, adv = 0;
   int          dp_waits = 0, need = 0, cyc = 0;
   bit          resp_pend = 0, resp_wr = 0, wr_out = 0, st_init = 0;
   int          resp_cnt = 0, st_cnt = 0;
   logic [31:0] resp_data = '0, last_rd = '0;
   mem_req_t    st_ref;

   initial begin
      bus.hsel = 1'b0; bus.htrans = 2'b00; bus.haddr = '0; bus.hsize = '0;
      bus.hburst = '0; bus.hwrite = 1'b0; bus.hwdata = '0;
      bus.mem_req_ready = 1'b0; bus.mem_resp_valid = 1'b0;
      bus.mem_resp = '0; bus.mem_resp.resp_last = 1'b1;

      add(32'h100, 2, 0, 32'h0,        32'hDEADBEEF, 0, 0, 1);
      add(32'h203, 0, 1, 32'h000000A5, 32'h0,        0, 0, 1);
      add(32'h101, 1, 0, 32'h0,        32'h0,        0, 0, 1);
      add(32'h300, 2, 0, 32'h0,        32'h12345678, 5, 3, 1);
      add(32'h010, 2, 0, 32'h0,        32'hCAFEF00D, 0, 0, 1);
      add(32'h014, 2, 1, 32'h55AA33CC, 32'h0,        0, 0, 0);
      add(32'h020, 2, 1, 32'h01020304, 32'h0,        0, 4, 1);
      add(32'h024, 2, 0, 32'h0,        32'hA1B2C3D4, 0, 0, 0);
      for (int i = 0; i < 150; i++) begin
         int r, sz;
         r  = $urandom_range(0, 7);
         sz = (r < 3) ? 0 : (r < 5) ? 1 : (r < 7) ? 2 : 3;
         add($urandom & 32'hFFFF, sz, 1'($urandom_range(0, 1)), $urandom, $urandom,
             $urandom_range(0, 5), $urandom_range(0, 4), $urandom_range(0, 2));
      end

      repeat (3) @(posedge clk);
      @(negedge clk);
      check("rst_hreadyout", bus.hreadyout, 1);
      check("rst_hresp", bus.hresp, 0);
      check("rst_hrdata", bus.hrdata, 0);
      check("rst_req_valid", bus.mem_req_valid, 0);
      check("rst_resp_ready", bus.mem_resp_ready, 0);
      @(posedge clk);
      #1 rstn = 1'b1;

      while (cyc < 20000 && (stim.size() > 0 || ap_valid || dp_act || resp_pend || expq.size() > 0)) begin
         @(negedge clk);
         cyc++;
         if (wr_out) check("post_hold", bus.mem_req_valid, 0);

         // mem response side
         if (resp_pend) begin
            if (resp_cnt > 0) begin
               resp_cnt--;
               bus.mem_resp_valid = 1'b0;
            end else begin
               bus.mem_resp_valid = 1'b1;
               bus.mem_resp.resp_data = resp_data;
               if (bus.mem_resp_ready) begin
                  resp_pend = 0;
                  if (resp_wr) wr_out = 0;
               end
            end
         end else begin
            bus.mem_resp_valid = 1'b0;
            bus.mem_resp.resp_data = $urandom;
         end

         // mem request side
         if (bus.mem_req_valid) begin
            if (expq.size() == 0) begin
               check("spurious_req", 1, 0);
               bus.mem_req_ready = 1'b0;
            end else begin
               if (!st_init) begin
                  st_init = 1; st_cnt = expq[0].stall; st_ref = bus.mem_req;
               end else begin
                  check("req_stable", bus.mem_req, st_ref);
               end
               if (st_cnt > 0) begin
                  st_cnt--;
                  bus.mem_req_ready = 1'b0;
               end else begin
                  bus.mem_req_ready = 1'b1;
                  t = expq.pop_front();
                  check("req_type", bus.mem_req.req_type, t.wr);
                  check("req_addr", bus.mem_req.req_addr, t.addr);
                  check("req_mask", bus.mem_req.req_mask, mask_f(t));
                  check("req_burst", bus.mem_req.req_burst, 1);
                  if (t.wr) check("req_data", bus.mem_req.req_data, t.wdata);
                  st_init = 0; resp_pend = 1; resp_cnt = t.dly; resp_data = t.rdata;
                  resp_wr = t.wr && POSTED;
                  if (resp_wr) wr_out = 1;
               end
            end
         end else begin
            bus.mem_req_ready = 1'($urandom_range(0, 1));
         end

         // AHB side
         adv = 0;
         if (dp_act) begin
            if (!bus.hreadyout) begin
               dp_waits++;
               check("wait_hresp", bus.hresp, !dp_legal);
               if (!dp_legal) check("err_no_req", bus.mem_req_valid, 0);
               if (dp_waits > 300) begin
                  check("timeout_xfer", 1, 0);
                  $fatal(1, "FAIL transfer stuck");
               end
            end else begin
               if (!dp_legal) need = 1;
               else if (POSTED && dp.wr) need = dp.stall + 1;
               else need = dp.stall + dp.dly + 2;
               if (dp_exact) check("waits", dp_waits, need);
               else check("waits_min", dp_waits >= need, 1);
               check("hresp", bus.hresp, !dp_legal);
               check("hrdata", bus.hrdata, (dp_legal && !dp.wr) ? dp.rdata : last_rd);
               if (dp_legal && !dp.wr) last_rd = dp.rdata;
               dp_act = 0;
               adv = 1;
            end
         end else begin
            check("idle_hreadyout", bus.hreadyout, 1);
            check("idle_hresp", bus.hresp, 0);
            check("idle_req_valid", bus.mem_req_valid, 0);
            adv = 1;
         end
         if (adv && ap_valid) begin
            dp = ap; dp_act = 1; dp_waits = 0; dp_legal = legal_f(ap);
            dp_exact = !wr_out;
            if (dp_legal) expq.push_back(ap);
            ap_valid = 0;
         end

         @(posedge clk);
         #1;
         if (adv) begin
            if (stim.size() > 0 && stim[0].gap == 0) begin
               ap = stim.pop_front();
               ap_valid = 1;
               bus.hsel = 1'b1; bus.htrans = 2'b10; bus.haddr = ap.addr;
               bus.hsize = 3'(ap.size); bus.hwrite = ap.wr; bus.hburst = 3'($urandom_range(0, 7));
            end else begin
               if (stim.size() > 0) stim[0].gap = stim[0].gap - 1;
               drive_idle();
            end
            bus.hwdata = (dp_act && dp.wr) ? dp.wdata : $urandom;
         end
      end
      if (cyc >= 20000) check("timeout_run", 1, 0);

      // reset while a request is pending
      @(negedge clk);
      bus.mem_req_ready = 1'b0;
      bus.mem_resp_valid = 1'b0;
      @(posedge clk);
      #1;
      bus.hsel = 1'b1; bus.htrans = 2'b10; bus.haddr = 32'h40; bus.hsize = 3'd2; bus.hwrite = 1'b0;
      @(posedge clk);
      #1 drive_idle();
      @(negedge clk);
      check("pre_rst_valid", bus.mem_req_valid, 1);
      check("pre_rst_hreadyout", bus.hreadyout, 0);
      rstn = 1'b0;
      @(posedge clk);
      #1 rstn = 1'b1;
      @(negedge clk);
      check("mid_rst_valid", bus.mem_req_valid, 0);
      check("mid_rst_hreadyout", bus.hreadyout, 1);
      check("mid_rst_resp_ready", bus.mem_resp_ready, 0);

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule

// File: doc/ahb2mem.md
Name: ahb2mem

Overview:
- AHB-Lite slave that converts single AHB transfers into mem_req/mem_resp transactions on the core memory interface.
- External or debug AHB masters use it to reach memory-side agents that speak the mem protocol, i.e. the slave end of an AHB link.
- Supports one outstanding transfer and single beats only.
- Inserts wait states via hreadyout until the mem side completes.

Parameters:
- N_AW, 32: AHB address width.
- N_DW, 32: AHB data width. Only 32 is supported.

Ports:
- clk  in  1  clock
- rstn  in  1  reset, synchronous, active-low
- hsel  in  1  slave select
- htrans  in  2  transfer type
- haddr  in  N_AW  address
- hsize  in  3  transfer size
- hburst  in  3  burst type; ignored, every beat is handled as a single transfer
- hwrite  in  1  1 = write
- hwdata  in  N_DW  write data, valid in the data phase
- hready  in  1  bus-level ready (address-phase qualifier)
- hreadyout  out  1  slave ready
- hresp  out  1  0 = OKAY, 1 = ERROR
- hrdata  out  N_DW  read data
- mem_req_valid  out  1  request valid
- mem_req_ready  in  1  request ready
- mem_req  out  mem_req_t  request: req_type, req_addr, req_data, req_mask, req_burst
- mem_resp_valid  in  1  response valid
- mem_resp_ready  out  1  response ready
- mem_resp  in  mem_resp_t  response: resp_type, resp_data, resp_last

Behaviour:
- Clock and reset: single clock clk; rstn is synchronous and active-low.
- Reset values: state=IDLE, hreadyout=1, hresp=0, hrdata=0, mem_req_valid=0, mem_resp_ready=0, all captured address-phase registers 0.
- Accept condition: acc = hsel & htrans[1] & hready, sampled only in IDLE, DONE or ERR2. On acc, latch haddr, hsize and hwrite.
- IDLE/BUSY htrans, or hsel=0: zero-wait OKAY; no mem activity.
- Legality check on the latched attributes:
  - legal = hsize<=WORD and address aligned to size (HALF: haddr[0]=0; WORD: haddr[1:0]=0).
  - If illegal, next state is ERR1; otherwise REQ.
- States:
  - IDLE: hreadyout=1, hresp=0.
  - REQ: hreadyout=0; mem_req_valid=1. On mem_req_ready → RESP.
  - RESP: hreadyout=0; mem_resp_ready=1. On mem_resp_valid, capture resp_data into hrdata (reads only; writes leave hrdata unchanged) → DONE.
  - DONE: hreadyout=1, hresp=0 for one cycle. On acc → REQ or ERR1; otherwise → IDLE.
  - ERR1: hreadyout=0, hresp=1 → ERR2.
  - ERR2: hreadyout=1, hresp=1. On acc → REQ or ERR1; otherwise → IDLE.
- mem_req field mapping:
  - req_type: MEM_WRITE or MEM_READ, from the latched hwrite.
  - req_addr: the latched haddr.
  - req_burst: 1.
  - req_data: hwdata, taken live; the AHB master holds it stable through the wait states.
- req_mask:
  - BYTE: 4'b0001 << addr[1:0].
  - HALF: 4'b0011 << {addr[1],1'b0}.
  - WORD: 4'hF.
- mem_req is held stable while mem_req_valid=1 and mem_req_ready=0.
- Latency with mem_req_ready=1 and the response one cycle after the request: address phase at T0; hreadyout low at T1 and T2; high at T3 with hrdata valid. That is 2 wait states minimum, reads and writes alike.
- Simultaneous events: a new address phase accepted in DONE/ERR2 is a pipelined transfer and enters REQ in the next cycle with no idle gap.
- Unsolicited mem_resp_valid outside RESP: not consumed (mem_resp_ready=0). In posted mode, drained as described under Optional Feature.
- Reset mid-operation: the FSM returns to IDLE immediately. mem_req_valid deasserts even without a handshake; the mem side is reset in the same domain.

Optional Feature:
- Macro: AHB2MEM_WR_POST_EN.
- Defined (posted writes):
  - A write REQ handshake goes directly to DONE.
  - A pend_wr flag sets on that handshake and clears when the write response arrives.
  - While pend_wr=1: mem_resp_ready=1 and the response is discarded; REQ holds mem_req_valid=0 until pend_wr clears. At most one outstanding response.
  - Write latency drops to 1 wait state.
- Undefined: writes wait for mem_resp as described under Behaviour; no pend_wr logic.

Test Plan:
- WORD read at haddr=0x100, resp_data=0xDEADBEEF one cycle after request → req_type=READ, req_mask=4'hF, req_burst=1; hrdata=0xDEADBEEF with hreadyout high at T3, hresp=0.
- BYTE write 0x000000A5 at haddr=0x203 → req_addr=0x203, req_mask=4'b1000, req_data equals hwdata; hreadyout low 2 cycles, then OKAY.
- HALF access at haddr=0x101 → no mem_req; hresp=1 for 2 cycles, hreadyout 0 then 1.
- mem_req_ready held low 5 cycles, then the response delayed 3 cycles → mem_req stable throughout; hreadyout low until DONE; exactly one mem_req handshake.
- Back-to-back NONSEQ read 0x10 then write 0x14, second address in DONE → second REQ the next cycle with correct type, address and mask.
- With AHB2MEM_WR_POST_EN: write then read, write response delayed 4 cycles → write completes after 1 wait; read mem_req_valid held 0 until the write response drains.
